scc_4lc_corrector: RTL and testbench
====================================

Name: scc_4lc_corrector

Overview:
Downstream stage of the SCC 4LC decoder: consumes a 71-bit codeword plus its 7-bit syndrome from the syndrome generator, locates and flips a single erroneous bit, and emits 64-bit corrected data with a status code. Two-stage pipeline with valid/ready handshake and saturating CE/DUE event counters for the RAS logic. Codeword layout: [70:7] data, [6:0] check bits.

Parameters:
CNT_W, 16, width of the CE and DUE event counters
PIPE_S2, 1, 1 = registered output stage (latency 2); 0 = stage 2 combinational (latency 1)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  codeword/syndrome valid
in_ready  out  1  stage can accept input
in_codeword  in  71  received codeword
in_syndrome  in  7  syndrome of in_codeword
out_valid  out  1  result valid
out_ready  in  1  downstream accepts result
out_data  out  64  corrected data (codeword[70:7])
out_status  out  2  00 NE, 01 CE, 10 DUE, 11 unused
out_err_pos  out  7  corrected bit index 0..70; 0 when not CE
ce_cnt  out  CNT_W  saturating count of CE results delivered
due_cnt  out  CNT_W  saturating count of DUE results delivered
cnt_clr  in  1  synchronous clear of both counters

Behaviour:
- Reset is asynchronous, active-low; single clock clk. During reset: out_valid=0, out_data=0, out_status=00, out_err_pos=0, ce_cnt=0, due_cnt=0; all stage valids=0. in_ready=1 one cycle after rst_n rises.
- Pipeline enable: en = !out_valid || out_ready; in_ready = en. All stages advance together when en=1; nothing moves when en=0 (no bubble collapsing).
- Transfer in: in_valid && in_ready. Transfer out: out_valid && out_ready.
- Stage 1 (registered): captures codeword, syndrome, valid; computes 71-bit match vector: match[i] = (syndrome == SCC_H_COL[i]) and syndrome != 0.
- Stage 2: syndrome==0 -> NE, data unchanged. Exactly one match bit set -> CE, flip that bit, out_err_pos = index; a match on a check column (0..6) leaves data unchanged but still reports CE. No match with nonzero syndrome -> DUE, data passed uncorrected, out_err_pos=0. More than one match (illegal H) -> DUE.
- Latency: in transfer at cycle N -> out_valid at N+2 (PIPE_S2=1) or N+1 (PIPE_S2=0), absent backpressure. Throughput 1 word/cycle when out_ready held high.
- Output fields hold stable while out_valid && !out_ready.
- Counters: increment on transfer out with status CE / DUE respectively; saturate at all-ones (no wrap). cnt_clr in same cycle as an increment: clear wins, increment dropped. Counters unaffected by stall.
- Reset mid-operation: in-flight words discarded, no counter update.

Decomposition:
- Package scc_4lc_pkg: SCC_N=71, SCC_K=64, SCC_R=7, status enum scc_status_t {NE, CE, DUE}, constant array SCC_H_COL[0:70] of 7-bit H-matrix columns (shared with encoder and syndrome generator).
- Sub-module scc_4lc_err_locate: combinational syndrome -> {match vector, err_pos, status}; instantiated in stage 1/2 boundary.

Test Plan:
- Codeword 71'h0, syndrome 0, out_ready=1 -> two cycles later out_data=64'h0, status NE, err_pos 0, counters unchanged.
- Codeword with only bit 70 set, syndrome 7'h0C -> out_data=64'h0, status CE, err_pos 70, ce_cnt=1.
- Codeword with only bit 0 set, syndrome 7'h01 -> out_data=64'h0 (data untouched), status CE, err_pos 0.
- Syndrome matching no column (e.g. 7'h7F if absent from H) with data 64'hDEAD_BEEF_0000_0001 -> data passed unchanged, status DUE, due_cnt increments.
- Stream 4 words back-to-back, out_ready low 3 cycles mid-stream -> in_ready drops, output held stable, all 4 delivered in order with no loss/duplication.
- Preload ce_cnt to all-ones via 2^CNT_W CE words (or CNT_W=4 build: 16 CEs) -> stays 15 on next CE; assert cnt_clr concurrent with a CE transfer -> ce_cnt=0; rst_n low mid-stream -> out_valid=0 immediately.

Source files
------------

// File: rtl/scc_4lc_pkg.sv
// Shared constants for the SCC 4LC code: geometry, result status encoding and
// the H-matrix columns used by the encoder, syndrome generator and corrector.
package scc_4lc_pkg;

  localparam int SCC_N = 71;  // codeword bits
  localparam int SCC_K = 64;  // data bits, codeword[70:7]
  localparam int SCC_R = 7;   // check bits, codeword[6:0]

  typedef enum logic [1:0] {
    NE  = 2'b00,  // no error
    CE  = 2'b01,  // corrected error
    DUE = 2'b10   // detected, uncorrectable error
  } scc_status_t;

  // Check columns 0..6 are unit vectors. Data columns 7..69 take the
  // non-unit values 3..71 in ascending order with 12 held back, and 12 is
  // placed on column 70. Every column is distinct and nonzero; 7'h7F is
  // deliberately not a column.
  localparam logic [SCC_R-1:0] SCC_H_COL [0:SCC_N-1] = '{
    7'd1,  7'd2,  7'd4,  7'd8,  7'd16, 7'd32, 7'd64,
    7'd3,  7'd5,  7'd6,  7'd7,  7'd9,  7'd10, 7'd11, 7'd13,
    7'd14, 7'd15, 7'd17, 7'd18, 7'd19, 7'd20, 7'd21, 7'd22,
    7'd23, 7'd24, 7'd25, 7'd26, 7'd27, 7'd28, 7'd29, 7'd30,
    7'd31, 7'd33, 7'd34, 7'd35, 7'd36, 7'd37, 7'd38, 7'd39,
    7'd40, 7'd41, 7'd42, 7'd43, 7'd44, 7'd45, 7'd46, 7'd47,
    7'd48, 7'd49, 7'd50, 7'd51, 7'd52, 7'd53, 7'd54, 7'd55,
    7'd56, 7'd57, 7'd58, 7'd59, 7'd60, 7'd61, 7'd62, 7'd63,
    7'd65, 7'd66, 7'd67, 7'd68, 7'd69, 7'd70, 7'd71, 7'd12
  };

endpackage

// File: rtl/scc_4lc_err_locate.sv
// Combinational error locator: maps a syndrome to the matching H columns,
// the single erroneous bit position and the result status.
module scc_4lc_err_locate
  import scc_4lc_pkg::*;
(
  input  logic [SCC_R-1:0] syndrome,
  output logic [SCC_N-1:0] match,
  output logic [6:0]       err_pos,
  output scc_status_t      status
);

  logic [6:0] pos_any;
  logic       one_hot;

  // Compare the syndrome against every H column; a zero syndrome matches none.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // through the block leaves it unassigned and infers a latch.
    match = '0;
    for (int i = 0; i < SCC_N; i++) begin
      match[i] = (syndrome == SCC_H_COL[i]) && (syndrome != '0);
    end
  end

  // Classify: NE on zero syndrome, CE on exactly one match, DUE otherwise.
  always_comb begin
    pos_any = '0;
    for (int i = 0; i < SCC_N; i++) begin
      if (match[i]) pos_any = 7'(i);
    end
    one_hot = (match != '0) && ((match & (match - SCC_N'(1))) == '0);
    if (syndrome == '0)  status = NE;
    else if (one_hot)    status = CE;
    else                 status = DUE;
    err_pos = (status == CE) ? pos_any : '0;
  end

endmodule

// File: rtl/scc_4lc_corrector.sv
// SCC 4LC corrector: two-stage valid/ready pipeline that flips a single
// erroneous codeword bit, reports NE/CE/DUE status and keeps saturating
// CE/DUE event counters for the RAS logic.
module scc_4lc_corrector
  import scc_4lc_pkg::*;
#(
  parameter int CNT_W   = 16,
  parameter bit PIPE_S2 = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [SCC_N-1:0] in_codeword,
  input  logic [SCC_R-1:0] in_syndrome,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [SCC_K-1:0] out_data,
  output logic [1:0]       out_status,
  output logic [6:0]       out_err_pos,
  output logic [CNT_W-1:0] ce_cnt,
  output logic [CNT_W-1:0] due_cnt,
  input  logic             cnt_clr
);

  logic             en;
  logic             s1_valid;
  logic [SCC_N-1:0] s1_cw;
  logic [SCC_R-1:0] s1_syn;
  logic [SCC_N-1:0] match;
  logic [6:0]       loc_pos;
  scc_status_t      loc_status;
  logic [SCC_N-1:0] corr_cw;
  logic             xfer_out;

  // The whole pipeline advances as one; a stalled output freezes every stage.
  assign en       = !out_valid || out_ready;
  assign in_ready = en;
  assign xfer_out = out_valid && out_ready;

  // Stage 1: capture codeword, syndrome and valid when the pipeline moves.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: the datapath registers are reset too, not just the valid, because
    // the combinational stage-2 build drives out_data straight from them and
    // the outputs must read zero while reset is held.
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_cw    <= '0;
      s1_syn   <= '0;
    end else if (en) begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples pre-edge values regardless of statement order.
      s1_valid <= in_valid;
      s1_cw    <= in_codeword;
      s1_syn   <= in_syndrome;
    end
  end

  scc_4lc_err_locate u_locate (
    .syndrome (s1_syn),
    .match    (match),
    .err_pos  (loc_pos),
    .status   (loc_status)
  );

  // Flip the located bit; a check-column hit only touches bits [6:0].
  always_comb begin
    corr_cw = s1_cw;
    if (loc_status == CE) corr_cw = s1_cw ^ match;
  end

  if (PIPE_S2) begin : g_s2_reg
    // Stage 2 registered: results advance with the rest of the pipeline.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        out_valid   <= 1'b0;
        out_data    <= '0;
        out_status  <= NE;
        out_err_pos <= '0;
      end else if (en) begin
        out_valid   <= s1_valid;
        out_data    <= corr_cw[SCC_N-1:SCC_R];
        out_status  <= loc_status;
        out_err_pos <= loc_pos;
      end
    end
  end else begin : g_s2_comb
    // Stage 2 combinational: results presented directly from stage 1.
    always_comb begin
      out_valid   = s1_valid;
      out_data    = corr_cw[SCC_N-1:SCC_R];
      out_status  = loc_status;
      out_err_pos = loc_pos;
    end
  end

  // Event counters: count delivered CE/DUE results, saturate, clear wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ce_cnt  <= '0;
      due_cnt <= '0;
    end else if (cnt_clr) begin
      ce_cnt  <= '0;
      due_cnt <= '0;
    end else if (xfer_out) begin
      if (out_status == CE && ce_cnt != '1)   ce_cnt  <= ce_cnt + CNT_W'(1);
      if (out_status == DUE && due_cnt != '1) due_cnt <= due_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_scc_4lc_corrector.sv
// Directed testbench for scc_4lc_corrector: latency for both stage-2 builds,
// NE/CE/DUE classification, backpressure ordering, counter saturation and
// clear priority, and reset mid-stream.
module tb_scc_4lc_corrector;

  localparam int CNT_W = 4;

  typedef struct packed {
    logic [63:0] data;
    logic [1:0]  st;
    logic [6:0]  pos;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic [70:0]      in_codeword = '0;
  logic [6:0]       in_syndrome = '0;
  logic             out_ready = 1'b1;
  logic             cnt_clr = 1'b0;

  logic             in_ready, out_valid;
  logic [63:0]      out_data;
  logic [1:0]       out_status;
  logic [6:0]       out_err_pos;
  logic [CNT_W-1:0] ce_cnt, due_cnt;

  logic             in_ready0, out_valid0;
  logic [63:0]      out_data0;
  logic [1:0]       out_status0;
  logic [6:0]       out_err_pos0;
  logic [CNT_W-1:0] ce_cnt0, due_cnt0;

  int   checks = 0;
  int   errors = 0;
  exp_t q[$];

  always #5 clk = ~clk;

  scc_4lc_corrector #(.CNT_W(CNT_W), .PIPE_S2(1'b1)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_codeword(in_codeword), .in_syndrome(in_syndrome),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_status(out_status), .out_err_pos(out_err_pos),
    .ce_cnt(ce_cnt), .due_cnt(due_cnt), .cnt_clr(cnt_clr)
  );

  scc_4lc_corrector #(.CNT_W(CNT_W), .PIPE_S2(1'b0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready0),
    .in_codeword(in_codeword), .in_syndrome(in_syndrome),
    .out_valid(out_valid0), .out_ready(out_ready), .out_data(out_data0),
    .out_status(out_status0), .out_err_pos(out_err_pos0),
    .ce_cnt(ce_cnt0), .due_cnt(due_cnt0), .cnt_clr(cnt_clr)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Called at a negedge; leaves at a negedge with in_valid low.
  task automatic send(input logic [70:0] cw, input logic [6:0] syn,
                      input logic [63:0] d, input logic [1:0] st, input logic [6:0] pos);
    int   n = 0;
    exp_t e;
    in_valid    = 1'b1;
    in_codeword = cw;
    in_syndrome = syn;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) check("in_ready_timeout", in_ready, 1'b1);
    else begin
      e.data = d; e.st = st; e.pos = pos;
      q.push_back(e);
    end
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((q.size() != 0 || out_valid) && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) check("drain_timeout", 64'(q.size()), 64'd0);
  endtask

  task automatic set_ready(input logic v);
    @(posedge clk);
    #1 out_ready = v;
    @(negedge clk);
  endtask

  // Scoreboard: every valid output must equal the oldest outstanding word.
  always @(negedge clk) begin
    if (rst_n && out_valid) begin
      if (q.size() == 0) check("spurious_out", out_valid, 1'b0);
      else begin
        check("out_data", out_data, q[0].data);
        check("out_status", out_status, q[0].st);
        check("out_err_pos", out_err_pos, q[0].pos);
        if (out_ready) void'(q.pop_front());
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    repeat (2) @(negedge clk);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_data", out_data, 64'h0);
    check("rst_out_status", out_status, 2'b00);
    check("rst_err_pos", out_err_pos, 7'd0);
    check("rst_ce_cnt", ce_cnt, 4'd0);
    check("rst_due_cnt", due_cnt, 4'd0);
    check("rst_out_valid0", out_valid0, 1'b0);
    check("rst_out_data0", out_data0, 64'h0);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_in_ready", in_ready, 1'b1);

    // Bit 70 error: latency 1 on the combinational build, 2 on the registered
    send({1'b1, 70'h0}, 7'h0C, 64'h0, 2'b01, 7'd70);
    check("lat1_valid0", out_valid0, 1'b1);
    check("lat1_data0", out_data0, 64'h0);
    check("lat1_status0", out_status0, 2'b01);
    check("lat1_pos0", out_err_pos0, 7'd70);
    check("lat1_valid", out_valid, 1'b0);
    @(negedge clk);
    check("lat2_valid", out_valid, 1'b1);
    drain();
    check("ce_after_t1", ce_cnt, 4'd1);
    check("due_after_t1", due_cnt, 4'd0);

    send(71'h0, 7'h00, 64'h0, 2'b00, 7'd0);
    send(71'h1, 7'h01, 64'h0, 2'b01, 7'd0);
    send({64'hDEAD_BEEF_0000_0001, 7'h00}, 7'h7F, 64'hDEAD_BEEF_0000_0001, 2'b10, 7'd0);
    send({64'hFFFF_FFFF_FFFF_FFFE, 7'h00}, 7'h03, 64'hFFFF_FFFF_FFFF_FFFF, 2'b01, 7'd7);
    send({64'h0123_4567_89AB_CDEF, 7'h08}, 7'h08, 64'h0123_4567_89AB_CDEF, 2'b01, 7'd3);
    drain();
    check("ce_after_dir", ce_cnt, 4'd4);
    check("due_after_dir", due_cnt, 4'd1);
    check("ce_after_dir0", ce_cnt0, 4'd4);

    // Back-to-back stream with a 3-cycle output stall
    fork
      begin
        send({64'h0123_4567_89AB_CDEF, 7'h00}, 7'h00, 64'h0123_4567_89AB_CDEF, 2'b00, 7'd0);
        send({64'h8000_0000_0000_00FF, 7'h00}, 7'h0C, 64'h0000_0000_0000_00FF, 2'b01, 7'd70);
        send({64'hA5A5_A5A5_A5A5_A5A5, 7'h55}, 7'h00, 64'hA5A5_A5A5_A5A5_A5A5, 2'b00, 7'd0);
        send({64'h5A5A_5A5A_5A5A_5A5A, 7'h00}, 7'h7F, 64'h5A5A_5A5A_5A5A_5A5A, 2'b10, 7'd0);
      end
      begin
        @(posedge clk);
        @(posedge clk);
        #1 out_ready = 1'b0;
        @(negedge clk);
        check("stall_in_ready", in_ready, 1'b0);
        check("stall_out_valid", out_valid, 1'b1);
        repeat (3) @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    drain();
    check("stream_ce", ce_cnt, 4'd5);
    check("stream_due", due_cnt, 4'd2);

    // Saturation of the 4-bit CE counter
    for (int i = 0; i < 10; i++) send(71'h1, 7'h01, 64'h0, 2'b01, 7'd0);
    drain();
    check("ce_full", ce_cnt, 4'd15);
    send(71'h1, 7'h01, 64'h0, 2'b01, 7'd0);
    drain();
    check("ce_sat", ce_cnt, 4'd15);

    // Clear concurrent with a CE transfer: clear wins
    set_ready(1'b0);
    send({1'b1, 70'h0}, 7'h0C, 64'h0, 2'b01, 7'd70);
    repeat (2) @(negedge clk);
    check("clr_held_valid", out_valid, 1'b1);
    check("clr_held_ce", ce_cnt, 4'd15);
    @(posedge clk);
    #1 cnt_clr = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    #1 cnt_clr = 1'b0;
    check("clr_ce", ce_cnt, 4'd0);
    check("clr_due", due_cnt, 4'd0);
    @(negedge clk);
    send(71'h1, 7'h01, 64'h0, 2'b01, 7'd0);
    drain();
    check("ce_after_clr", ce_cnt, 4'd1);

    // Reset with two words in flight
    set_ready(1'b0);
    send({64'h1111_2222_3333_4444, 7'h00}, 7'h00, 64'h1111_2222_3333_4444, 2'b00, 7'd0);
    send({64'h5555_6666_7777_8888, 7'h00}, 7'h00, 64'h5555_6666_7777_8888, 2'b00, 7'd0);
    check("pre_rst_valid", out_valid, 1'b1);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_out_valid", out_valid, 1'b0);
    check("midrst_out_data", out_data, 64'h0);
    check("midrst_ce", ce_cnt, 4'd0);
    q.delete();
    out_ready = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    send({64'hCAFE_F00D_0000_0000, 7'h00}, 7'h03, 64'hCAFE_F00D_0000_0001, 2'b01, 7'd7);
    drain();
    check("post_midrst_ce", ce_cnt, 4'd1);
    check("post_midrst_due", due_cnt, 4'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
